// File: rtl/branch_resolver.sv
// Registered branch-resolution stage: evaluates RV32I B-type conditions, forms the
// branch target and redirect PC, and keeps saturating taken/mispredict event counters.
module branch_resolver #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] mispredict_count
);

  logic            accept;
  logic            deliver;
  logic            equal;
  logic            signed_lt;
  logic            unsigned_lt;
  logic            cond_next;
  logic            illegal_next;
  logic [XLEN-1:0] target_next;
  logic [XLEN-1:0] seq_next;

  logic            out_valid_reg;
  logic            taken_reg;
  logic [XLEN-1:0] target_reg;
  logic [XLEN-1:0] redirect_reg;
  logic            mispredict_reg;
  logic            illegal_reg;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign deliver  = out_valid_reg && out_ready;

  assign equal       = (rs1_val == rs2_val);
  assign signed_lt   = ($signed(rs1_val) < $signed(rs2_val));
  assign unsigned_lt = (rs1_val < rs2_val);
  assign target_next = pc + imm;
  assign seq_next    = pc + XLEN'(4);

  always_comb begin
    cond_next    = 1'b0;
    illegal_next = 1'b0;
    case (funct3)
      3'b000:  cond_next = equal;
      3'b001:  cond_next = !equal;
      3'b100:  cond_next = signed_lt;
      3'b101:  cond_next = !signed_lt;
      3'b110:  cond_next = unsigned_lt;
      3'b111:  cond_next = !unsigned_lt;
      default: illegal_next = 1'b1;
    endcase
  end

  // Flush wins over accept and delivery; result fields only load on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      taken_reg      <= 1'b0;
      target_reg     <= '0;
      redirect_reg   <= '0;
      mispredict_reg <= 1'b0;
      illegal_reg    <= 1'b0;
    end else begin
      if (flush)        out_valid_reg <= 1'b0;
      else if (accept)  out_valid_reg <= 1'b1;
      else if (deliver) out_valid_reg <= 1'b0;
      if (accept) begin
        taken_reg      <= cond_next;
        target_reg     <= target_next;
        redirect_reg   <= cond_next ? target_next : seq_next;
        mispredict_reg <= cond_next != pred_taken;
        illegal_reg    <= illegal_next;
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign taken       = taken_reg;
  assign target      = target_reg;
  assign redirect_pc = redirect_reg;
  assign mispredict  = mispredict_reg;
  assign illegal     = illegal_reg;

  // Counter 0 tracks taken, counter 1 tracks mispredict; a flushed result is never counted.
  logic [1:0]            event_bits;
  logic [1:0][CNT_W-1:0] count_all;

  assign event_bits = {mispredict_reg, taken_reg};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
      logic [CNT_W-1:0] count_reg;
      always_ff @(posedge clk) begin
        if (rst)
          count_reg <= '0;
        else if (deliver && !flush && event_bits[gi] && (count_reg != {CNT_W{1'b1}}))
          count_reg <= count_reg + CNT_W'(1);
      end
      assign count_all[gi] = count_reg;
    end
  endgenerate

  assign taken_count      = count_all[0];
  assign mispredict_count = count_all[1];

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (CNT_W=4 to reach saturation).
module tb_branch_resolver;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_val, rs2_val, pc, imm;
  logic             pred_taken;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [XLEN-1:0]  target, redirect_pc;
  logic             mispredict, illegal;
  logic [CNT_W-1:0] taken_count, mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_resolver #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .target(target),
    .redirect_pc(redirect_pc), .mispredict(mispredict), .illegal(illegal),
    .taken_count(taken_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && out_valid && out_ready && !flush)
      $display("txn delivered: taken=%0b target=%08h redirect=%08h mispredict=%0b illegal=%0b",
               taken, target, redirect_pc, mispredict, illegal);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, input logic pt);
    in_valid = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; pc = p; imm = i; pred_taken = pt;
  endtask

  // Flags are {out_valid, taken, mispredict, illegal}.
  task automatic check_out(input string name, input logic [3:0] flags,
                           input logic [31:0] exp_tgt, input logic [31:0] exp_rpc);
    checks++;
    if ({out_valid, taken, mispredict, illegal} !== flags) begin
      errors++;
      $display("FAIL %s flags got=%04b exp=%04b", name, {out_valid, taken, mispredict, illegal}, flags);
    end
    checks++;
    if (target !== exp_tgt || redirect_pc !== exp_rpc) begin
      errors++;
      $display("FAIL %s addr got tgt=%08h rpc=%08h exp tgt=%08h rpc=%08h",
               name, target, redirect_pc, exp_tgt, exp_rpc);
    end
  endtask

  task automatic check_cnt(input string name, input logic [3:0] exp_t, input logic [3:0] exp_m);
    checks++;
    if (taken_count !== exp_t || mispredict_count !== exp_m) begin
      errors++;
      $display("FAIL %s counters got t=%0d m=%0d exp t=%0d m=%0d",
               name, taken_count, mispredict_count, exp_t, exp_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    funct3 = 3'b000; rs1_val = '0; rs2_val = '0; pc = '0; imm = '0; pred_taken = 1'b0;
    step(); step();
    rst = 1'b0;
    check_out("reset", 4'b0000, 32'h0, 32'h0);
    check_cnt("reset", 4'd0, 4'd0);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_beq();
    out_ready = 1'b0;
    drive(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0);
    step();
    in_valid = 1'b0;
    check_out("beq", 4'b1110, 32'h120, 32'h120);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL beq_drain out_valid got=%0b exp=0", out_valid); end
    check_cnt("beq", 4'd1, 4'd1);
  endtask

  task automatic test_signed_unsigned();
    out_ready = 1'b1;
    drive(3'b100, 32'hFFFFFFFF, 32'h1, 32'h1000, 32'h40, 1'b0);
    step();
    check_out("blt", 4'b1110, 32'h1040, 32'h1040);
    drive(3'b110, 32'hFFFFFFFF, 32'h1, 32'h2000, 32'h40, 1'b0);
    step();
    check_out("bltu", 4'b1000, 32'h2040, 32'h2004);
    drive(3'b101, 32'hFFFFFFFF, 32'h1, 32'h3000, 32'h40, 1'b0);
    step();
    check_out("bge", 4'b1000, 32'h3040, 32'h3004);
    drive(3'b111, 32'hFFFFFFFF, 32'h1, 32'h4000, 32'h40, 1'b0);
    step();
    check_out("bgeu", 4'b1110, 32'h4040, 32'h4040);
    in_valid = 1'b0;
    step();
    check_cnt("signed_unsigned", 4'd3, 4'd3);
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    drive(3'b001, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h8, 1'b0);
    step();
    in_valid = 1'b0;
    check_out("wrap_bne", 4'b1000, 32'h00000004, 32'h00000000);
    step();
    check_cnt("wrap", 4'd3, 4'd3);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(3'b000, 32'h1, 32'h1, 32'h200, 32'h10, 1'b1);
    step();
    check_out("bp_held", 4'b1100, 32'h210, 32'h210);
    drive(3'b001, 32'h1, 32'h2, 32'h300, 32'hFFFFFFFC, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got=%0b exp=0", k, in_ready); end
      step();
      check_out("bp_stall", 4'b1100, 32'h210, 32'h210);
      check_cnt("bp_stall", 4'd3, 4'd3);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%0b exp=1", in_ready); end
    step();
    check_out("bp_next", 4'b1110, 32'h2FC, 32'h2FC);
    check_cnt("bp_release", 4'd4, 4'd3);
    in_valid = 1'b0;
    step();
    check_cnt("bp_next_drain", 4'd5, 4'd4);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(3'b000, 32'h1, 32'h2, 32'h500, 32'h10, 1'b1);
    step();
    check_out("flush_held", 4'b1010, 32'h510, 32'h504);
    drive(3'b000, 32'h9, 32'h9, 32'h400, 32'h10, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    check_cnt("flush", 4'd5, 4'd4);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%0b exp=0", out_valid); end
    check_cnt("flush_after", 4'd5, 4'd4);
  endtask

  task automatic test_illegal_saturate();
    out_ready = 1'b1;
    drive(3'b010, 32'h3, 32'h3, 32'h600, 32'h20, 1'b1);
    step();
    check_out("illegal_010", 4'b1011, 32'h620, 32'h604);
    drive(3'b011, 32'h3, 32'h3, 32'h700, 32'h20, 1'b1);
    step();
    check_out("illegal_011", 4'b1011, 32'h720, 32'h704);
    // 4 + 14 deliveries overshoots 15, so the counter must pin there.
    for (int k = 0; k < 12; k++) step();
    in_valid = 1'b0;
    step();
    check_cnt("saturate", 4'd5, 4'hF);
    step();
    check_cnt("saturate_hold", 4'd5, 4'hF);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(3'b000, 32'h4, 32'h4, 32'h800, 32'h10, 1'b0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    check_out("reset_mid", 4'b0000, 32'h0, 32'h0);
    check_cnt("reset_mid", 4'd0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_wrap();
    test_backpressure();
    test_flush();
    test_illegal_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
